// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-source result FIFOs with round-robin grant onto registered CDB slots
module cdb_arbiter #(
  parameter int N_SRC      = 4,
  parameter int CDB_PORTS  = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int PREG_W     = 6,
  parameter int ROB_W      = 5
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     flush,
  input  logic [N_SRC-1:0]                         src_valid,
  output logic [N_SRC-1:0]                         src_ready,
  input  logic [N_SRC-1:0][PREG_W-1:0]             src_rd,
  input  logic [N_SRC-1:0][ROB_W-1:0]              src_rob_id,
  input  logic [N_SRC-1:0][31:0]                   src_value,
  output logic [CDB_PORTS-1:0]                     cdb_valid,
  output logic [CDB_PORTS-1:0][PREG_W-1:0]         cdb_rd,
  output logic [CDB_PORTS-1:0][ROB_W-1:0]          cdb_rob_id,
  output logic [CDB_PORTS-1:0][31:0]               cdb_value,
  output logic [CDB_PORTS-1:0][$clog2(N_SRC)-1:0]  cdb_src
);
  localparam int SRC_W = $clog2(N_SRC);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = PREG_W + ROB_W + 32;

  logic [ENT_W-1:0] mem   [N_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] head  [N_SRC];
  logic [PTR_W-1:0] tail  [N_SRC];
  logic [CNT_W-1:0] count [N_SRC];
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] rr_next;
  logic [N_SRC-1:0] push;
  logic [N_SRC-1:0] grant;

  logic [SRC_W-1:0] pos_src  [N_SRC];
  logic [N_SRC-1:0] pos_take;
  int               pos_rank [N_SRC];
  int               taken;
  logic [SRC_W:0]   sum;

  logic [CDB_PORTS-1:0] slot_vld;
  logic [ENT_W-1:0]     slot_ent [CDB_PORTS];
  logic [SRC_W-1:0]     slot_src [CDB_PORTS];

  // Ready comes from registered occupancy only, so a same-cycle pop never opens the FIFO.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_ready[i] = (count[i] != CNT_W'(FIFO_DEPTH));
    end
    push = src_valid & src_ready;
  end

  always_comb begin
    taken    = 0;
    sum      = '0;
    grant    = '0;
    pos_take = '0;
    rr_next  = rr_ptr;
    for (int k = 0; k < N_SRC; k++) begin
      sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (sum >= (SRC_W+1)'(N_SRC)) sum = sum - (SRC_W+1)'(N_SRC);
      pos_src[k]  = sum[SRC_W-1:0];
      pos_rank[k] = taken;
      if (count[pos_src[k]] != '0 && taken < CDB_PORTS) begin
        pos_take[k]        = 1'b1;
        grant[pos_src[k]]  = 1'b1;
        taken              = taken + 1;
        rr_next            = (pos_src[k] == SRC_W'(N_SRC-1)) ? '0 : pos_src[k] + SRC_W'(1);
      end
    end
  end

  // Slot p carries the p-th granted source in scan order.
  always_comb begin
    slot_vld = '0;
    for (int p = 0; p < CDB_PORTS; p++) begin
      slot_ent[p] = '0;
      slot_src[p] = '0;
      for (int k = 0; k < N_SRC; k++) begin
        if (pos_take[k] && pos_rank[k] == p) begin
          slot_vld[p] = 1'b1;
          slot_src[p] = pos_src[k];
          slot_ent[p] = mem[pos_src[k]][head[pos_src[k]]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (push[i]) mem[i][tail[i]] <= {src_rd[i], src_rob_id[i], src_value[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) rr_ptr <= '0;
    else if (!flush) rr_ptr <= rr_next;

    if (!rst || flush) begin
      for (int i = 0; i < N_SRC; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
      cdb_valid  <= '0;
      cdb_rd     <= '0;
      cdb_rob_id <= '0;
      cdb_value  <= '0;
      cdb_src    <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (push[i])  tail[i] <= tail[i] + PTR_W'(1);
        if (grant[i]) head[i] <= head[i] + PTR_W'(1);
        if (push[i] && !grant[i])      count[i] <= count[i] + CNT_W'(1);
        else if (!push[i] && grant[i]) count[i] <= count[i] - CNT_W'(1);
      end
      for (int p = 0; p < CDB_PORTS; p++) begin
        cdb_valid[p]                                  <= slot_vld[p];
        {cdb_rd[p], cdb_rob_id[p], cdb_value[p]}      <= slot_ent[p];
        cdb_src[p]                                    <= slot_src[p];
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
  localparam int N_SRC = 4;
  localparam int CDB_PORTS = 2;
  localparam int ENT_W = 6 + 5 + 32;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       flush = 1'b0;
  logic [N_SRC-1:0]           src_valid = '0;
  logic [N_SRC-1:0]           src_ready;
  logic [N_SRC-1:0][5:0]      src_rd = '0;
  logic [N_SRC-1:0][4:0]      src_rob_id = '0;
  logic [N_SRC-1:0][31:0]     src_value = '0;
  logic [CDB_PORTS-1:0]       cdb_valid;
  logic [CDB_PORTS-1:0][5:0]  cdb_rd;
  logic [CDB_PORTS-1:0][4:0]  cdb_rob_id;
  logic [CDB_PORTS-1:0][31:0] cdb_value;
  logic [CDB_PORTS-1:0][1:0]  cdb_src;

  int errors = 0;
  int checks = 0;
  logic [ENT_W-1:0] exp_q [N_SRC][$];
  logic [ENT_W-1:0] ent;

  cdb_arbiter #(.N_SRC(N_SRC), .CDB_PORTS(CDB_PORTS), .FIFO_DEPTH(2), .PREG_W(6), .ROB_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready), .src_rd(src_rd),
    .src_rob_id(src_rob_id), .src_value(src_value),
    .cdb_valid(cdb_valid), .cdb_rd(cdb_rd), .cdb_rob_id(cdb_rob_id),
    .cdb_value(cdb_value), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < N_SRC; i++) n += exp_q[i].size();
    return n;
  endfunction

  // Every CDB slot is matched against the per-source expectation queue.
  always @(negedge clk) begin
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (cdb_valid[p]) begin
        int s;
        s = int'(cdb_src[p]);
        checks++;
        assert (exp_q[s].size() > 0) else begin
          errors++;
          $error("FAIL unexpected_cdb slot%0d: got src %0d expected none", p, s);
        end
        if (exp_q[s].size() > 0) begin
          ent = exp_q[s].pop_front();
          check("cdb_entry", 64'({cdb_rd[p], cdb_rob_id[p], cdb_value[p]}), 64'(ent));
        end
      end else begin
        check("idle_slot_zero", 64'({cdb_src[p], cdb_rd[p], cdb_rob_id[p], cdb_value[p]}), 64'(0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [5:0] rd, input logic [4:0] rob,
                         input logic [31:0] val, input bit expect_it);
    src_valid[i]  = 1'b1;
    src_rd[i]     = rd;
    src_rob_id[i] = rob;
    src_value[i]  = val;
    if (expect_it) exp_q[i].push_back({rd, rob, val});
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N_SRC; i++) exp_q[i].delete();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (pending() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(pending()), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush = 1'b0;
    src_valid = 4'($urandom);
    step();
    src_valid = 4'($urandom);
    src_value = {$urandom, $urandom, $urandom, $urandom};
    step();
    @(negedge clk);
    check("rst_cdb_valid", 64'(cdb_valid), 64'(0));
    check("rst_ready", 64'(src_ready), 64'(4'hf));
    rst = 1'b1;
    src_valid = '0;
    clear_queues();
    step();
    @(negedge clk);
    check("post_rst_cdb_valid", 64'(cdb_valid), 64'(0));
    check("post_rst_ready", 64'(src_ready), 64'(4'hf));
  endtask

  task automatic rr_burst(input string tag);
    for (int i = 0; i < N_SRC; i++) set_src(i, 6'(i + 8), 5'(i + 16), $urandom, 1'b1);
    step();
    src_valid = '0;
    @(negedge clk);
    check({tag, "_latency"}, 64'(cdb_valid), 64'(0));
    step();
    @(negedge clk);
    check({tag, "_c1_valid"}, 64'(cdb_valid), 64'(2'b11));
    check({tag, "_c1_src0"}, 64'(cdb_src[0]), 64'(0));
    check({tag, "_c1_src1"}, 64'(cdb_src[1]), 64'(1));
    step();
    @(negedge clk);
    check({tag, "_c2_valid"}, 64'(cdb_valid), 64'(2'b11));
    check({tag, "_c2_src0"}, 64'(cdb_src[0]), 64'(2));
    check({tag, "_c2_src1"}, 64'(cdb_src[1]), 64'(3));
    step();
    @(negedge clk);
    check({tag, "_idle"}, 64'(cdb_valid), 64'(0));
  endtask

  initial begin
    do_reset();

    // single result from source 1
    set_src(1, 6'd5, 5'd3, 32'hDEAD_BEEF, 1'b1);
    step();
    src_valid = '0;
    @(negedge clk);
    check("single_not_early", 64'(cdb_valid), 64'(0));
    step();
    @(negedge clk);
    check("single_valid", 64'(cdb_valid), 64'(2'b01));
    check("single_src", 64'(cdb_src[0]), 64'(1));
    check("single_rd", 64'(cdb_rd[0]), 64'(5));
    check("single_rob", 64'(cdb_rob_id[0]), 64'(3));
    check("single_value", 64'(cdb_value[0]), 64'(32'hDEAD_BEEF));

    do_reset();
    rr_burst("rr1");
    rr_burst("rr2");
    drain("rr_drain");

    // backpressure on source 0 while 2 and 3 hold the arbiter
    do_reset();
    set_src(0, 6'd1, 5'd1, 32'h0000_0A00, 1'b1);
    set_src(1, 6'd2, 5'd2, 32'h0000_0A01, 1'b1);
    set_src(2, 6'd3, 5'd3, 32'h0000_0A02, 1'b1);
    set_src(3, 6'd4, 5'd4, 32'h0000_0A03, 1'b1);
    step();
    src_valid = '0;
    set_src(0, 6'd10, 5'd10, 32'h0000_0C01, 1'b1);
    set_src(2, 6'd11, 5'd11, 32'h0000_0B02, 1'b1);
    set_src(3, 6'd12, 5'd12, 32'h0000_0B03, 1'b1);
    step();
    src_valid = '0;
    set_src(0, 6'd13, 5'd13, 32'h0000_0C02, 1'b1);
    check("bp_ready_one_queued", 64'(src_ready[0]), 64'(1));
    step();
    src_valid = '0;
    set_src(0, 6'd14, 5'd14, 32'h0000_0C03, 1'b0);
    check("bp_ready_full", 64'(src_ready[0]), 64'(0));
    step();
    check("bp_ready_after_pop", 64'(src_ready[0]), 64'(1));
    exp_q[0].push_back({6'd14, 5'd14, 32'h0000_0C03});
    step();
    src_valid = '0;
    drain("bp_drain");

    // flush with FIFOs loaded and CDB busy
    for (int i = 0; i < N_SRC; i++) set_src(i, 6'(i + 20), 5'(i), $urandom, 1'b1);
    step();
    for (int i = 0; i < N_SRC; i++) set_src(i, 6'(i + 30), 5'(i + 8), $urandom, 1'b1);
    step();
    src_valid = '0;
    flush = 1'b1;
    set_src(0, 6'd63, 5'd31, 32'hF1F1_F1F1, 1'b0);
    @(negedge clk);
    check("pre_flush_valid", 64'(cdb_valid), 64'(2'b11));
    step();
    flush = 1'b0;
    src_valid = '0;
    clear_queues();
    @(negedge clk);
    check("flush_valid", 64'(cdb_valid), 64'(0));
    check("flush_ready", 64'(src_ready), 64'(4'hf));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("flush_quiet", 64'(cdb_valid), 64'(0));
    end

    // rd=0 still broadcasts
    set_src(2, 6'd0, 5'd7, 32'h1234_5678, 1'b1);
    step();
    src_valid = '0;
    step();
    @(negedge clk);
    check("rd0_valid", 64'(cdb_valid), 64'(2'b01));
    check("rd0_rd", 64'(cdb_rd[0]), 64'(0));
    check("rd0_rob", 64'(cdb_rob_id[0]), 64'(7));
    check("rd0_src", 64'(cdb_src[0]), 64'(2));
    drain("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Collects completed results from the functional units (ALU, MUL, LSQ) and drives the common data bus consumed by the physical register file, reservation stations and ROB. Each source pushes results through a valid/ready handshake into a private FIFO. A round-robin arbiter grants up to `CDB_PORTS` FIFO heads per cycle onto registered CDB slots. This block is the transmitting end of the CDB writeback interface.

## Interface
Parameters:
- `N_SRC`, default 4: number of result sources (N_ALU + N_MUL + LSQ).
- `CDB_PORTS`, default 2: CDB slots driven per cycle; must be ≤ N_SRC.
- `FIFO_DEPTH`, default 2: entries per source FIFO; power of two, ≥ 2.
- `PREG_W`, default 6: physical register index width.
- `ROB_W`, default 5: ROB id width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset (asserted when 0).
- `flush`  in  1  pipeline flush (mispredict); synchronous clear.
- `src_valid`  in  [N_SRC]  source presents a result.
- `src_ready`  out  [N_SRC]  FIFO can accept this cycle.
- `src_rd`  in  [N_SRC][PREG_W]  destination physical register.
- `src_rob_id`  in  [N_SRC][ROB_W]  ROB id.
- `src_value`  in  [N_SRC][32]  result value.
- `cdb_valid`  out  [CDB_PORTS]  slot carries a result (maps to `ready_for_writeback`).
- `cdb_rd`  out  [CDB_PORTS][PREG_W]  slot destination register.
- `cdb_rob_id`  out  [CDB_PORTS][ROB_W]  slot ROB id.
- `cdb_value`  out  [CDB_PORTS][32]  slot value.
- `cdb_src`  out  [CDB_PORTS][$clog2(N_SRC)]  granted source index (debug/verification).

## Operation
- Per source: circular FIFO with head/tail pointers and a count of width $clog2(FIFO_DEPTH)+1. `src_ready[i]` = (count < FIFO_DEPTH), derived from registered state only. Ready does not depend on same-cycle pops.
- Push: `src_valid[i] & src_ready[i]` writes {rd, rob_id, value} at tail. When valid is high and ready is low, the source holds its fields unchanged.
- Arbitration (combinational on FIFO heads):
  - Scan sources starting at `rr_ptr`, wrapping modulo N_SRC.
  - Grant the first CDB_PORTS non-empty sources. Slot 0 gets the first in scan order, slot 1 the next, and so on.
  - Each source gets at most one grant per cycle.
- Pop: each granted FIFO pops at the edge. Simultaneous push and pop on the same FIFO leaves count unchanged.
- `rr_ptr` advances to (last granted index + 1) mod N_SRC. It is unchanged when nothing is granted.
- Per-source order is preserved. No ordering is guaranteed across sources.
- Fairness: any non-empty head is granted within ceil(N_SRC/CDB_PORTS) cycles.
- `rd == 0` results are broadcast normally. Consumers ignore the register write; the ROB still needs the completion.
- Unused slots: `cdb_valid=0`. `rd`, `rob_id`, `value` and `src` are driven to 0.
- Flush: at the edge, all FIFO counts and pointers clear, all `cdb_valid` clear, and `rr_ptr` holds. Any push presented in the flush cycle is discarded.
- Reset (`rst=0` at an edge) clears all state regardless of other inputs, including mid-transfer.

## Timing
- Reset values: `cdb_valid=0`, all cdb fields 0, `src_ready` all 1, `rr_ptr=0`, all FIFOs empty.
- CDB outputs are registered. A result pushed at edge E is granted in cycle E..E+1 at the earliest and appears on `cdb_*` after edge E+1. Minimum latency is 2 edges; there is no push-to-CDB bypass.
- Each `cdb_valid` is a one-cycle pulse per result. There is no CDB backpressure.
- After a push fills a FIFO at edge E, ready drops in the following cycle. A pop at edge E restores ready for the cycle after E.
- Flush takes priority over push and grant. Reset takes priority over flush.

## Test plan
- Reset: hold `rst=0` for 2 cycles with random `src_valid` → all `cdb_valid=0`, all `src_ready=1`, FIFOs empty after release.
- Single result: source 1 pushes rd=5, rob=3, value=0xDEADBEEF → exactly two edges later, slot 0 has valid=1, rd=5, rob_id=3, value=0xDEADBEEF, src=1, and slot 1 has valid=0.
- Round-robin (N_SRC=4, CDB_PORTS=2):
  - All four sources push one result in the same cycle.
  - Next-cycle CDB shows src {0,1}; the cycle after shows {2,3}.
  - Repeat the burst → {0,1} then {2,3} again, with no source skipped.
- Backpressure: source 0 pushes 3 results back-to-back while sources 1–3 are busy → `src_ready[0]` low after 2 pushes. Results appear in push order, and the third push is accepted only after the first pop.
- Flush: with 2 results queued in each FIFO and valid slots on the CDB, assert `flush` for one cycle → next cycle all `cdb_valid=0` and all ready=1. The result pushed during the flush cycle never appears.
- rd=0: a push with rd=0 and rob=7 → broadcast with valid=1, rd=0, rob_id=7 after 2 edges.
